ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/ifetch_unit.sv | 131 +++++++++++++
 tb/tb_ifetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, NOP encoding, default
// reset PC, fetch FSM state encoding and the instruction-buffer entry layout.
package riscv_pkg;
  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // One buffered instruction; pc sits in the upper half of the 64-bit word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} words for decode.
// Ports:
//   clk, reset              clock, async active-high reset
//   flush_i                 drop all entries (wins over push)
//   push_i / push_data_i    write an entry (accepted when not full or popping)
//   pop_i                   remove the head (ignored when empty)
//   head_o                  entry at the head (undefined when empty)
//   full_o, empty_o, count_o occupancy status
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, buffers returned
// instructions with their PCs, and handles redirects by flushing the buffer
// and discarding responses to requests already in flight.
// Ports:
//   clk, reset                         clock, async active-high reset
//   redirect_valid, redirect_pc        taken branch/jump from execute
//   imem_req_valid/addr/ready          fetch request handshake
//   imem_rsp_valid/data                in-order instruction return
//   dec_valid/instr/pc, dec_ready      buffered instruction to decode
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;   // PC of the next response to keep
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W:0]   inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic             accept, dec_pop, discard, rsp_push;
  logic [XLEN-1:0]  redirect_tgt;
  fetch_entry_t     push_entry, head_entry;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit: a slot popped this cycle is free for a response that can only
  // arrive next cycle at the earliest, so it counts as available now.
  assign dec_valid = ~fifo_empty;
  assign dec_pop   = dec_valid & dec_ready;
  assign inflight  = (CNT_W+1)'(outst_q) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(dec_pop);

  assign imem_req_valid = ~reset & (state_q == FETCH) & (inflight < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // Anything returning while stale requests remain, or in the redirect cycle
  // itself, belongs to the old path.
  assign discard  = redirect_valid | (drop_q != '0);
  assign rsp_push = imem_rsp_valid & ~discard;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    drop_d     = drop_q;

    if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CNT_W'(1);
    if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(4);

    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      // Everything still owed after this edge is stale.
      drop_d     = outst_d;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    case (state_q)
      FETCH:   if (redirect_valid && drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (rsp_push),
    .push_data_i (push_entry),
    .pop_i       (dec_pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Head storage is not reset, so mask it to present zeros when empty.
  assign dec_instr = fifo_empty ? '0 : head_entry.instr;
  assign dec_pc    = fifo_empty ? '0 : head_entry.pc;

  // The credit rule must always leave room for a kept response.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rsp_push && fifo_full && !dec_pop));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed scenarios for ifetch_unit with a scoreboard of expected decode
// words and a fixed-latency memory model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;

  logic        mem_ready = 1'b1;
  int          mem_lat = 1;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb [$];

  ifetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // Memory: answers every accepted request after mem_lat (1 or 2) cycles.
  logic [1:0]  mv;
  logic [31:0] md0, md1;
  assign imem_req_ready = mem_ready;
  assign imem_rsp_valid = (mem_lat == 1) ? mv[0] : mv[1];
  assign imem_rsp_data  = (mem_lat == 1) ? md0 : md1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mv  <= '0;
      md0 <= '0;
      md1 <= '0;
    end else begin
      mv[0] <= imem_req_valid & imem_req_ready;
      md0   <= instr_of(imem_req_addr);
      mv[1] <= mv[0];
      md1   <= md0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_fill(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Called #1 after a negedge: scores a pending decode handshake, updates
  // the expected stream on a redirect, then moves to the next negedge.
  task automatic adv();
    logic [31:0] ep;
    if (dec_valid && dec_ready) begin
      ep = 32'hDEAD_BEE0;
      if (sb.size() != 0) ep = sb.pop_front();
      check("sb_dec_pc", dec_pc, ep);
      check("sb_dec_instr", dec_instr, instr_of(ep));
    end
    if (redirect_valid) sb_fill({redirect_pc[31:2], 2'b00});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      #1;
      adv();
    end
  endtask

  // Reset asserted mid low phase; outputs must clear before the next edge.
  task automatic do_reset(input int lat);
    #2;
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    mem_lat = lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_fill(32'h0);
  endtask

  initial begin
    int acc;
    @(negedge clk);

    // Startup: back-to-back fetches, first decode two cycles after accept.
    do_reset(1);
    dec_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("s1_req_valid", 32'(imem_req_valid), 32'd1);
      check("s1_req_addr", imem_req_addr, 32'(4 * (c - 1)));
      check("s1_dec_valid", 32'(dec_valid), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) check("s1_dec_pc", dec_pc, 32'h0);
      adv();
    end
    run(8);

    // Decode stall: credit stops fetching at two, head held steady.
    do_reset(1);
    dec_ready = 1'b0;
    acc = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (imem_req_valid && mem_ready) acc++;
      if (c >= 3) begin
        check("s2_dec_valid", 32'(dec_valid), 32'd1);
        check("s2_hold_pc", dec_pc, 32'h0);
        check("s2_hold_instr", dec_instr, instr_of(32'h0));
      end
      if (c == 6) check("s2_req_stall", 32'(imem_req_valid), 32'd0);
      adv();
    end
    check("s2_accepts", 32'(acc), 32'd2);
    dec_ready = 1'b1;
    #1;
    check("s2_resume_valid", 32'(imem_req_valid), 32'd1);
    check("s2_resume_addr", imem_req_addr, 32'h8);
    adv();
    run(8);

    // Redirect with two requests outstanding (2-cycle memory).
    do_reset(2);
    dec_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    check("s3_req_full", 32'(imem_req_valid), 32'd0);
    adv();
    redirect_valid = 1'b0;
    #1;
    check("s3_drain_req", 32'(imem_req_valid), 32'd0);
    check("s3_drain_dec", 32'(dec_valid), 32'd0);
    adv();
    #1;
    check("s3_tgt_valid", 32'(imem_req_valid), 32'd1);
    check("s3_tgt_addr", imem_req_addr, 32'h0000_0100);
    check("s3_tgt_dec", 32'(dec_valid), 32'd0);
    adv();
    run(10);

    // Redirect together with a decode handshake and a memory response.
    do_reset(1);
    dec_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("s4_hs_valid", 32'(dec_valid), 32'd1);
    adv();
    redirect_valid = 1'b0;
    #1;
    check("s4_empty", 32'(dec_valid), 32'd0);
    adv();
    #1;
    check("s4_tgt_valid", 32'(imem_req_valid), 32'd1);
    check("s4_tgt_addr", imem_req_addr, 32'h0000_0200);
    adv();
    run(8);

    // Redirect with a full buffer: handshake word kept, the other flushed.
    do_reset(1);
    dec_ready = 1'b0;
    run(5);
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    adv();
    redirect_valid = 1'b0;
    #1;
    check("s4b_flushed", 32'(dec_valid), 32'd0);
    adv();
    run(8);

    // Address wrap at the top of memory.
    do_reset(1);
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    #1;
    adv();
    redirect_valid = 1'b0;
    #1;
    check("s5_drain_req", 32'(imem_req_valid), 32'd0);
    adv();
    #1;
    check("s5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("s5_top_valid", 32'(imem_req_valid), 32'd1);
    adv();
    #1;
    check("s5_wrap_addr", imem_req_addr, 32'h0);
    check("s5_wrap_valid", 32'(imem_req_valid), 32'd1);
    adv();
    run(6);

    // Reset with two requests in flight; restart from the reset PC.
    do_reset(2);
    dec_ready = 1'b0;
    run(2);
    do_reset(2);
    dec_ready = 1'b1;
    #1;
    check("s6_first_valid", 32'(imem_req_valid), 32'd1);
    check("s6_first_addr", imem_req_addr, 32'h0);
    adv();
    run(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
